// File: rtl/systolic_fir_array_if.sv
// Sample, coefficient-programming and result signals of the systolic FIR array.
// The array takes the slave side; the sample source / result sink takes the master side.
interface systolic_fir_array_if #(
  parameter int TAPS   = 8,
  parameter int DATA_W = 16,
  parameter int COEF_W = 16
);
  localparam int AW = $clog2(TAPS);

  logic                     in_valid;
  logic signed [DATA_W-1:0] xin;
  logic                     flush;
  logic                     coef_we;
  logic [AW-1:0]            coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     out_valid;
  logic signed [DATA_W-1:0] yout;

  modport slave (
    input  in_valid, xin, flush, coef_we, coef_addr, coef_data,
    output out_valid, yout
  );

  modport master (
    output in_valid, xin, flush, coef_we, coef_addr, coef_data,
    input  out_valid, yout
  );
endinterface

// File: rtl/systolic_fir_array.sv
// Transposed-form systolic FIR: one tap cell per coefficient, sample broadcast to all cells,
// partial sums ripple toward tap 0, then one round/saturate output stage.

module systolic_fir_tap #(
  parameter int                       DATA_W = 16,
  parameter int                       COEF_W = 16,
  parameter int                       ACC_W  = 35,
  parameter logic signed [COEF_W-1:0] H_RST  = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_i,
  input  logic                     clr_i,
  input  logic                     coef_we_i,
  input  logic signed [COEF_W-1:0] coef_i,
  input  logic signed [DATA_W-1:0] x_i,
  input  logic [ACC_W-1:0]         zin_i,
  output logic [ACC_W-1:0]         z_o
);
  localparam int PW = DATA_W + COEF_W;

  logic signed [COEF_W-1:0] h_q;
  logic signed [PW-1:0]     prod;
  logic [ACC_W-1:0]         z_q, z_d;

  assign prod = h_q * x_i;
  assign z_d  = {{(ACC_W-PW){prod[PW-1]}}, prod} + zin_i;
  assign z_o  = z_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            z_q <= '0;
    else if (clr_i)     z_q <= '0;
    else if (load_i)    z_q <= z_d;
  end

  // Coefficient writes are independent of flush; a sample on the same edge sees the old h_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            h_q <= H_RST;
    else if (coef_we_i) h_q <= coef_i;
  end
endmodule

module systolic_fir_array #(
  parameter int TAPS   = 8,
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int FRAC   = 14,
  parameter int ACC_W  = DATA_W + COEF_W + $clog2(TAPS)
) (
  input  logic                 clk30x,
  input  logic                 rst,
  systolic_fir_array_if.slave  bus
);
  localparam int AW = $clog2(TAPS);
  // FRAC >= 1 assumed: half-LSB rounding constant.
  localparam logic signed [ACC_W:0] RND  = (ACC_W+1)'(1) <<< (FRAC - 1);
  localparam logic signed [ACC_W:0] YMAX = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] YMIN = {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

  logic                    load;
  logic [TAPS:0][ACC_W-1:0] zc;
  logic [TAPS-1:0]         cwe;
  logic [2:1]              vld_pipe_q;
  logic signed [ACC_W:0]   rnd, shf;
  logic [DATA_W-1:0]       y_d, yout_q;

  assign load     = bus.in_valid & ~bus.flush;
  assign zc[TAPS] = '0;

  // zc[0] is the accumulator; zc[k] for k>=1 are the partial-sum registers z[k].
  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    assign cwe[k] = bus.coef_we && (bus.coef_addr == AW'(k));

    systolic_fir_tap #(
      .DATA_W (DATA_W),
      .COEF_W (COEF_W),
      .ACC_W  (ACC_W),
      .H_RST  (COEF_W'(k == 0 ? (1 << FRAC) : 0))
    ) u_tap (
      .clk       (clk30x),
      .rst       (rst),
      .load_i    (load),
      .clr_i     (bus.flush),
      .coef_we_i (cwe[k]),
      .coef_i    (bus.coef_data),
      .x_i       (bus.xin),
      .zin_i     (zc[k+1]),
      .z_o       (zc[k])
    );
  end

  assign rnd = $signed({zc[0][ACC_W-1], zc[0]}) + RND;
  assign shf = rnd >>> FRAC;

  always_comb begin
    y_d = shf[DATA_W-1:0];
    if (shf > YMAX)      y_d = YMAX[DATA_W-1:0];
    else if (shf < YMIN) y_d = YMIN[DATA_W-1:0];
  end

  // vld_pipe_q[1]: acc holds an unreported sample; vld_pipe_q[2]: out_valid pulse.
  always_ff @(posedge clk30x or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      yout_q     <= '0;
    end else if (bus.flush) begin
      vld_pipe_q <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[1], load};
      if (vld_pipe_q[1]) yout_q <= y_d;
    end
  end

  assign bus.out_valid = vld_pipe_q[2];
  assign bus.yout      = yout_q;
endmodule

// File: tb/tb_systolic_fir_array.sv
// Directed bench for systolic_fir_array: pass-through, impulse response, sparse input,
// rounding/saturation, flush and async reset mid-stream, coefficient write collisions.
module tb_systolic_fir_array;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  systolic_fir_array_if #(.TAPS(8), .DATA_W(16), .COEF_W(20)) bus ();
  systolic_fir_array_if #(.TAPS(5), .DATA_W(16), .COEF_W(16)) b5 ();

  systolic_fir_array #(.TAPS(8), .DATA_W(16), .COEF_W(20), .FRAC(14)) dut (
    .clk30x (clk),
    .rst    (rst),
    .bus    (bus.slave)
  );

  systolic_fir_array #(.TAPS(5), .DATA_W(16), .COEF_W(16), .FRAC(14)) dut5 (
    .clk30x (clk),
    .rst    (rst),
    .bus    (b5.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic wcoef(input int a, input int d);
    bus.coef_we   = 1'b1;
    bus.coef_addr = a[2:0];
    bus.coef_data = d[19:0];
    tick();
    bus.coef_we   = 1'b0;
  endtask

  task automatic send(input int x);
    bus.in_valid = 1'b1;
    bus.xin      = x[15:0];
    tick();
    bus.in_valid = 1'b0;
    tick();
  endtask

  // Back-to-back samples; output for sample i is checked on the edge of sample i+1.
  task automatic stream(input string tag, input int xs[$], input int es[$]);
    for (int i = 0; i < xs.size(); i++) begin
      bus.in_valid = 1'b1;
      bus.xin      = xs[i][15:0];
      tick();
      if (i > 0) begin
        chk({tag, "_ov"}, {15'd0, bus.out_valid}, 16'd1);
        chk({tag, "_y"}, bus.yout, es[i-1][15:0]);
      end
    end
    bus.in_valid = 1'b0;
    tick();
    chk({tag, "_ov_last"}, {15'd0, bus.out_valid}, 16'd1);
    chk({tag, "_y_last"}, bus.yout, es[xs.size()-1][15:0]);
  endtask

  task automatic prog_ramp();
    for (int k = 0; k < 8; k++) wcoef(k, (k + 1) << 14);
  endtask

  initial begin
    bus.in_valid = 0; bus.xin = '0; bus.flush = 0;
    bus.coef_we  = 0; bus.coef_addr = '0; bus.coef_data = '0;
    b5.in_valid  = 0; b5.xin = '0; b5.flush = 0;
    b5.coef_we   = 0; b5.coef_addr = '0; b5.coef_data = '0;

    // 1. reset state and unity pass-through
    repeat (2) tick();
    chk("rst_yout", bus.yout, 16'h0000);
    chk("rst_ov", {15'd0, bus.out_valid}, 16'd0);
    rst = 1'b0;
    bus.in_valid = 1'b1; bus.xin = 16'h1234;
    tick();
    bus.in_valid = 1'b0;
    chk("pt_ov_early", {15'd0, bus.out_valid}, 16'd0);
    tick();
    chk("pt_ov", {15'd0, bus.out_valid}, 16'd1);
    chk("pt_y1234", bus.yout, 16'h1234);
    tick();
    chk("pt_ov_pulse", {15'd0, bus.out_valid}, 16'd0);
    chk("pt_y_hold", bus.yout, 16'h1234);
    send(32'h8000);
    chk("pt_y8000", bus.yout, 16'h8000);

    // 2. impulse response, back-to-back
    prog_ramp();
    stream("imp", '{100, 0, 0, 0, 0, 0, 0, 0, 0, 0},
                  '{100, 200, 300, 400, 500, 600, 700, 800, 0, 0});

    // 3. sparse impulse: 5 idle cycles after each sample
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.xin      = (i == 0) ? 16'd100 : 16'd0;
      tick();
      bus.in_valid = 1'b0;
      chk("sp_ov_lat1", {15'd0, bus.out_valid}, 16'd0);
      tick();
      chk("sp_ov", {15'd0, bus.out_valid}, 16'd1);
      chk("sp_y", bus.yout, (i < 8) ? 16'((i + 1) * 100) : 16'd0);
      tick();
      chk("sp_ov_idle", {15'd0, bus.out_valid}, 16'd0);
      repeat (3) tick();
    end

    // 4. rounding and saturation from reset coefficients
    rst = 1'b1; tick(); rst = 1'b0;
    wcoef(0, 32'h2000);
    send(1);          chk("rnd_p1", bus.yout, 16'h0001);
    send(-1);         chk("rnd_m1", bus.yout, 16'h0000);
    send(-3);         chk("rnd_m3", bus.yout, 16'hFFFF);
    wcoef(0, 32'h7FFF);
    send(32'h7FFF);   chk("sat_pos", bus.yout, 16'h7FFF);
    send(-32768);     chk("sat_neg", bus.yout, 16'h8000);

    // 5a. flush on the edge carrying the third zero
    rst = 1'b1; tick(); rst = 1'b0;
    prog_ramp();
    bus.in_valid = 1'b1; bus.xin = 16'd100; tick();
    bus.xin = 16'd0; tick();
    chk("fl_y100", bus.yout, 16'd100);
    tick();
    chk("fl_y200", bus.yout, 16'd200);
    bus.flush = 1'b1; tick();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    tick();
    chk("fl_no_ov", {15'd0, bus.out_valid}, 16'd0);
    tick();
    chk("fl_no_ov2", {15'd0, bus.out_valid}, 16'd0);
    stream("fl_imp", '{50, 0, 0, 0, 0, 0, 0, 0, 0},
                     '{50, 100, 150, 200, 250, 300, 350, 400, 0});

    // 5b. async reset pulsed between edges
    bus.in_valid = 1'b1; bus.xin = 16'd100; tick();
    bus.xin = 16'd0; tick();
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("ar_yout", bus.yout, 16'h0000);
    chk("ar_ov", {15'd0, bus.out_valid}, 16'd0);
    #1 rst = 1'b0;
    tick();
    chk("ar_no_ov", {15'd0, bus.out_valid}, 16'd0);
    stream("ar_unity", '{77, 0}, '{77, 0});

    // 6. coefficient write colliding with a sample
    bus.coef_we = 1'b1; bus.coef_addr = 3'd0; bus.coef_data = 20'h02000;
    bus.in_valid = 1'b1; bus.xin = 16'd200;
    tick();
    bus.coef_we = 1'b0; bus.in_valid = 1'b0;
    tick();
    chk("cw_old", bus.yout, 16'd200);
    send(200);
    chk("cw_new", bus.yout, 16'd100);

    // 6b. out-of-range addresses on a 5-tap array leave it a pass-through
    for (int a = 5; a < 8; a++) begin
      b5.coef_we = 1'b1; b5.coef_addr = 3'(a); b5.coef_data = 16'h0000;
      tick();
    end
    b5.coef_we = 1'b0;
    b5.in_valid = 1'b1; b5.xin = 16'd77; tick();
    b5.in_valid = 1'b0; tick();
    chk("oor_ov", {15'd0, b5.out_valid}, 16'd1);
    chk("oor_y", b5.yout, 16'd77);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
